perf_interval_capture: RTL and testbench
========================================

Name: perf_interval_capture

Overview:
- Consumes the free-running 32-bit cycle count produced by the performance counter stage.
- Timestamps start/stop event pulses from the accelerator control path and computes the elapsed cycles of each interval.
- Buffers per-interval results in a small first-word-fall-through (FWFT) FIFO for host readout.
- Maintains running statistics: sample count, total, min, max, drop count, protocol error.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- TOT_W, 48, width of the total-cycles accumulator, in bits; 33..64.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cycle_cnt  in  32  free-running cycle count from the upstream counter; wraps modulo 2^32
- start  in  1  interval-start pulse, one cycle
- stop  in  1  interval-end pulse, one cycle
- clear  in  1  synchronous clear of state, statistics and FIFO
- rd_en  in  1  pop FIFO head; ignored when empty
- busy  out  1  interval in progress (state RUN)
- rd_data  out  32  FIFO head (elapsed cycles); valid when !empty
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- n_samples  out  32  completed intervals since clear; saturates at 0xFFFFFFFF
- total_cycles  out  TOT_W  sum of elapsed values; saturates at all-ones
- min_cycles  out  32  smallest elapsed value; 0xFFFFFFFF when no samples
- max_cycles  out  32  largest elapsed value; 0 when no samples
- drop_cnt  out  16  samples lost to FIFO full; saturates at 0xFFFF
- proto_err  out  1  sticky; set on start in RUN or stop in IDLE

Behaviour:
- Reset (rst=1, async):
  - state=IDLE, start_ts=0, FIFO empty (rd_ptr=wr_ptr=0).
  - busy=0, empty=1, full=0, rd_data=0.
  - n_samples=0, total_cycles=0, min_cycles=0xFFFFFFFF, max_cycles=0, drop_cnt=0, proto_err=0.
- clear (sync):
  - Same values as reset, applied on the next clk edge.
  - Highest priority: start, stop and rd_en are ignored in a clear cycle.
- State machine:
  - IDLE, start=1: start_ts <= cycle_cnt; goto RUN.
  - IDLE, stop=1 without start: no capture; proto_err <= 1.
  - RUN, stop=1: elapsed = cycle_cnt - start_ts (32-bit modular, so a single wrap is handled correctly); commit the sample; goto IDLE.
  - RUN, start=1 without stop: ignored; start_ts unchanged; proto_err <= 1.
  - start=stop=1 in IDLE: start taken; stop ignored; no error.
  - start=stop=1 in RUN: stop taken; goto IDLE; start ignored; no error.
- Sample commit (single clock edge):
  - Push elapsed if !full, else drop_cnt++.
  - n_samples++.
  - total_cycles += zero-extended elapsed (saturating).
  - min/max updated by unsigned compare.
  - Statistics update even when the FIFO push is dropped.
- Latency:
  - The stop edge registers the sample.
  - empty deasserts and rd_data is valid in the cycle after the stop cycle.
  - Statistics outputs reflect the sample in that same cycle.
- FIFO:
  - FWFT; rd_data is registered from the head entry.
  - rd_en with !empty pops; the new head is visible in the next cycle.
  - Push and pop in the same cycle are both allowed, including when full (push succeeds, no drop) and when empty with a push (pop ignored).
  - Pointers are log2(DEPTH)+1 bits: full when MSBs differ and the rest are equal; empty when all bits are equal.
- Reset mid-interval: capture is abandoned; no partial sample is produced.
- cycle_cnt is sampled only on start/stop edges; other values are don't-care.
- Intervals of 2^32 cycles or longer alias; this is documented as a limitation.

Decomposition:
- Shared package perf_pkg: CYC_W=32, DROP_W=16, state encoding IDLE=1'b0 / RUN=1'b1, MIN_INIT=32'hFFFF_FFFF.
- One sub-module, perf_sample_fifo: parameterized DEPTH x 32 FWFT FIFO with push/pop/full/empty, owning the pointers and the registered head.
- Top level holds the FSM, the elapsed-time subtractor and the statistics registers.

Test Plan:
- After reset, start at cycle_cnt=100 and stop at cycle_cnt=350 -> next cycle: rd_data=250, empty=0, n_samples=1, total=250, min=max=250, busy=0.
- Wrap case: start at 0xFFFFFFF0, stop at 0x00000010 -> rd_data=0x20; proto_err stays 0.
- With DEPTH=16, complete 18 intervals without reading -> full=1, drop_cnt=2, n_samples=18; popping 16 times returns samples 1..16 in order, then empty=1.
- Protocol errors: stop in IDLE, then start twice -> proto_err=1, sample count unchanged; start_ts equals the first start; a following stop yields elapsed measured from the first start.
- Full FIFO with a stop and rd_en in the same cycle -> no drop, count stays 16, head advances; clear during RUN -> next cycle busy=0, empty=1, min=0xFFFFFFFF, all stats 0.
- Async reset asserted mid-RUN and off clock edge -> outputs reach reset values immediately; after release, stop alone -> proto_err=1, no sample.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and constants for the interval-capture performance block.
package perf_pkg;
  localparam int CYC_W  = 32;
  localparam int DROP_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CYC_W-1:0] MIN_INIT = 32'hFFFF_FFFF;
endpackage

// File: rtl/perf_sample_fifo.sv
// First-word-fall-through sample FIFO; the head is held in a register so
// dout is a clean flop output.
module perf_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         accept,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !clear && !empty;
  // A pop frees a slot in the same edge, so a full FIFO still accepts.
  assign accept  = !full || do_pop;
  assign do_push = push && !clear && accept;

  always_comb begin
    rd_ptr_n = rd_ptr + {{AW{1'b0}}, do_pop};
    wr_ptr_n = wr_ptr + {{AW{1'b0}}, do_push};
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      // New head is the word being written when the FIFO is (or drains to) empty.
      if (do_push && (rd_ptr_n[AW-1:0] == wr_ptr[AW-1:0]))
        dout <= din;
      else
        dout <= mem[rd_ptr_n[AW-1:0]];
    end
  end
endmodule

// File: rtl/perf_interval_capture.sv
// Timestamps start/stop pulses against the free-running cycle count, queues
// each elapsed interval and keeps running statistics.
module perf_interval_capture
  import perf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TOT_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cycle_cnt,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              rd_en,
  output logic              busy,
  output logic [31:0]       rd_data,
  output logic              empty,
  output logic              full,
  output logic [31:0]       n_samples,
  output logic [TOT_W-1:0]  total_cycles,
  output logic [31:0]       min_cycles,
  output logic [31:0]       max_cycles,
  output logic [15:0]       drop_cnt,
  output logic              proto_err
);
  state_t             state;
  logic [CYC_W-1:0]   start_ts;
  logic [CYC_W-1:0]   elapsed;
  logic               commit, accept;
  logic [TOT_W:0]     tot_sum;

  // Modular subtraction makes a single counter wrap come out right.
  assign elapsed = cycle_cnt - start_ts;
  assign commit  = !clear && (state == RUN) && stop;
  assign tot_sum = {1'b0, total_cycles} + {{(TOT_W+1-CYC_W){1'b0}}, elapsed};
  assign busy    = (state == RUN);

  perf_sample_fifo #(.DEPTH(DEPTH), .W(CYC_W)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .push   (commit),
    .pop    (rd_en),
    .din    (elapsed),
    .accept (accept),
    .dout   (rd_data),
    .empty  (empty),
    .full   (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      start_ts <= '0;
      proto_err <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      start_ts <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            start_ts <= cycle_cnt;
            state    <= RUN;
          end else if (stop) begin
            proto_err <= 1'b1;
          end
        end
        RUN: begin
          if (stop)       state     <= IDLE;
          else if (start) proto_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Statistics follow every committed sample, dropped or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_samples    <= '0;
      total_cycles <= '0;
      min_cycles   <= MIN_INIT;
      max_cycles   <= '0;
      drop_cnt     <= '0;
    end else if (clear) begin
      n_samples    <= '0;
      total_cycles <= '0;
      min_cycles   <= MIN_INIT;
      max_cycles   <= '0;
      drop_cnt     <= '0;
    end else if (commit) begin
      if (n_samples != '1) n_samples <= n_samples + 32'd1;
      total_cycles <= tot_sum[TOT_W] ? '1 : tot_sum[TOT_W-1:0];
      if (elapsed < min_cycles) min_cycles <= elapsed;
      if (elapsed > max_cycles) max_cycles <= elapsed;
      if (!accept && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_perf_interval_capture.sv
// Scoreboard bench: stop pulses queue expected samples, a negedge monitor
// compares each popped head; statistics are checked directly.
module tb_perf_interval_capture;
  logic        clk = 0, rst = 1;
  logic [31:0] cycle_cnt = 0;
  logic        start = 0, stop = 0, clear = 0, rd_en = 0;
  logic        busy, empty, full, proto_err;
  logic [31:0] rd_data, n_samples, min_cycles, max_cycles;
  logic [47:0] total_cycles;
  logic [15:0] drop_cnt;

  int n_checks = 0, n_pass = 0;
  logic [31:0] exp_q[$];

  perf_interval_capture #(.DEPTH(16), .TOT_W(48)) dut (
    .clk(clk), .rst(rst), .cycle_cnt(cycle_cnt), .start(start), .stop(stop),
    .clear(clear), .rd_en(rd_en), .busy(busy), .rd_data(rd_data), .empty(empty),
    .full(full), .n_samples(n_samples), .total_cycles(total_cycles),
    .min_cycles(min_cycles), .max_cycles(max_cycles), .drop_cnt(drop_cnt),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted pop must present the oldest expected sample.
  always @(negedge clk) begin
    if (!rst && !clear && rd_en && !empty) begin
      if (exp_q.size() == 0) check("pop_unexpected", 64'(rd_data), 64'hDEAD);
      else check("pop_data", 64'(rd_data), 64'(exp_q.pop_front()));
    end
  end

  task automatic cyc(input logic s, input logic p, input logic [31:0] c, input logic r);
    start = s; stop = p; cycle_cnt = c; rd_en = r;
    @(posedge clk); #1;
    start = 0; stop = 0; rd_en = 0;
  endtask

  task automatic do_clear();
    clear = 1; @(posedge clk); #1; clear = 0;
    exp_q.delete();
  endtask

  task automatic stats(input string tag, input logic [31:0] n, input logic [47:0] t,
                       input logic [31:0] mn, input logic [31:0] mx, input logic [15:0] d);
    check({tag, "_n"},     64'(n_samples),    64'(n));
    check({tag, "_total"}, 64'(total_cycles), 64'(t));
    check({tag, "_min"},   64'(min_cycles),   64'(mn));
    check({tag, "_max"},   64'(max_cycles),   64'(mx));
    check({tag, "_drop"},  64'(drop_cnt),     64'(d));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_busy", 64'(busy), 0);
    check("rst_empty", 64'(empty), 1);
    check("rst_full", 64'(full), 0);
    check("rst_rd_data", 64'(rd_data), 0);
    check("rst_err", 64'(proto_err), 0);
    stats("rst", 0, 0, 32'hFFFF_FFFF, 0, 0);

    // Basic interval 100 -> 350
    cyc(1, 0, 100, 0);
    check("run_busy", 64'(busy), 1);
    exp_q.push_back(250);
    cyc(0, 1, 350, 0);
    check("s1_empty", 64'(empty), 0);
    check("s1_head", 64'(rd_data), 250);
    check("s1_busy", 64'(busy), 0);
    stats("s1", 1, 250, 250, 250, 0);
    cyc(0, 0, 0, 1);
    check("s1_drained", 64'(empty), 1);

    // Counter wrap
    cyc(1, 0, 32'hFFFF_FFF0, 0);
    exp_q.push_back(32'h20);
    cyc(0, 1, 32'h0000_0010, 0);
    check("wrap_head", 64'(rd_data), 32'h20);
    check("wrap_err", 64'(proto_err), 0);
    stats("wrap", 2, 282, 32'h20, 250, 0);
    cyc(0, 0, 0, 1);

    // Overflow: 18 intervals of length 1..18, last two dropped
    do_clear();
    for (int i = 0; i < 18; i++) begin
      cyc(1, 0, 1000, 0);
      if (i < 16) exp_q.push_back(32'(i + 1));
      cyc(0, 1, 32'(1000 + i + 1), 0);
    end
    check("ovf_full", 64'(full), 1);
    stats("ovf", 18, 171, 1, 18, 2);

    // Stop and pop together while full: push accepted, no drop
    cyc(1, 0, 2000, 0);
    exp_q.push_back(50);
    cyc(0, 1, 2050, 1);
    check("fullpp_full", 64'(full), 1);
    stats("fullpp", 19, 221, 1, 50, 2);
    check("fullpp_head", 64'(rd_data), 2);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1);
    check("drain_empty", 64'(empty), 1);
    check("drain_full", 64'(full), 0);

    // Protocol errors
    do_clear();
    cyc(0, 1, 400, 0);
    check("pe_stop_idle", 64'(proto_err), 1);
    check("pe_no_sample", 64'(n_samples), 0);
    cyc(1, 0, 500, 0);
    cyc(1, 0, 600, 0);
    exp_q.push_back(200);
    cyc(0, 1, 700, 0);
    check("pe_err_sticky", 64'(proto_err), 1);
    stats("pe", 1, 200, 200, 200, 0);
    cyc(0, 0, 0, 1);

    // start=stop together in IDLE starts, in RUN stops; no error
    do_clear();
    cyc(1, 1, 10, 0);
    check("both_idle_busy", 64'(busy), 1);
    exp_q.push_back(30);
    cyc(1, 1, 40, 0);
    check("both_run_busy", 64'(busy), 0);
    check("both_err", 64'(proto_err), 0);
    cyc(0, 0, 0, 1);

    // Clear during RUN with a sample pending
    cyc(1, 0, 5, 0);
    cyc(0, 1, 9, 0);
    cyc(1, 0, 20, 0);
    do_clear();
    check("clr_busy", 64'(busy), 0);
    check("clr_empty", 64'(empty), 1);
    stats("clr", 0, 0, 32'hFFFF_FFFF, 0, 0);

    // Async reset mid-RUN, off the clock edge
    cyc(1, 0, 77, 0);
    #3 rst = 1;
    #1;
    check("arst_busy", 64'(busy), 0);
    check("arst_err", 64'(proto_err), 0);
    @(posedge clk); #1 rst = 0;
    cyc(0, 1, 99, 0);
    check("arst_stop_err", 64'(proto_err), 1);
    check("arst_no_sample", 64'(n_samples), 0);
    check("arst_empty", 64'(empty), 1);

    check("scoreboard_left", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
